buf0_rgb_sequencer: RTL and testbench

//  Upstream controller and capture stage for the Buffer0 byte multiplexer.

---
 rtl/buf0_rgb_sequencer_if.sv | 28 ++
 rtl/buf0_rgb_sequencer.sv | 139 +++++++++++++
 tb/tb_buf0_rgb_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/buf0_rgb_sequencer_if.sv
// Bus bundle between the RGB sequencer, the Buffer0 multiplexer and the display-side consumer.
interface buf0_rgb_sequencer_if #(
  parameter int unsigned AW = 3
) ();
  logic        pix_start;
  logic [7:0]  MuxBuf0;
  logic        SelR0;
  logic        SelG0;
  logic        SelB0;
  logic [23:0] pix_out;
  logic        pix_valid;
  logic        pix_ready;
  logic        busy;
  logic [AW:0] fifo_count;
  logic        start_drop;

  // Sequencer side: drives the selects and the pixel stream.
  modport master (
    input  pix_start, MuxBuf0, pix_ready,
    output SelR0, SelG0, SelB0, pix_out, pix_valid, busy, fifo_count, start_drop
  );

  // Environment side: multiplexer, start requester and pixel consumer.
  modport slave (
    output pix_start, MuxBuf0, pix_ready,
    input  SelR0, SelG0, SelB0, pix_out, pix_valid, busy, fifo_count, start_drop
  );
endinterface

// File: rtl/buf0_rgb_sequencer.sv
// Buffer0 RGB sequencer: steps the one-hot mux selects, captures R/G/B bytes,
// packs them into a 24-bit pixel and queues it in a first-word-fall-through FIFO.
module buf0_rgb_sequencer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input logic                   clk,
  input logic                   rst,
  buf0_rgb_sequencer_if.master  bus
);

  typedef enum logic [2:0] {StIdle, StRed, StGrn, StBlu, StPush} state_e;

  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  state_e          state_q, state_d;
  logic            sel_r_q, sel_g_q, sel_b_q;
  logic            sel_r_d, sel_g_d, sel_b_d;
  logic            busy;
  logic [7:0]      r_q, g_q, b_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic            drop_q;
  logic [23:0]     mem [DEPTH];
  logic            full, valid, push, pop;

  // FIFO status and transfer strobes.
  always_comb begin
    full  = (count_q == FullCount);
    valid = (count_q != '0);
    push  = (state_q == StPush);
    pop   = valid && bus.pix_ready;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; space is reserved in IDLE so PUSH can never overflow.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.pix_start && !full) state_d = StRed;
      StRed:   state_d = StGrn;
      StGrn:   state_d = StBlu;
      StBlu:   state_d = StPush;
      StPush:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode; selects are decoded from the next state so they can be registered.
  always_comb begin
    sel_r_d = (state_d == StRed);
    sel_g_d = (state_d == StGrn);
    sel_b_d = (state_d == StBlu);
    busy    = (state_q != StIdle);
  end

  // Registered selects; cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_r_q <= 1'b0;
      sel_g_q <= 1'b0;
      sel_b_q <= 1'b0;
    end else begin
      sel_r_q <= sel_r_d;
      sel_g_q <= sel_g_d;
      sel_b_q <= sel_b_d;
    end
  end

  // Capture the muxed byte on the edge that ends each colour state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= 8'h00;
      g_q <= 8'h00;
      b_q <= 8'h00;
    end else begin
      if (state_q == StRed) r_q <= bus.MuxBuf0;
      if (state_q == StGrn) g_q <= bus.MuxBuf0;
      if (state_q == StBlu) b_q <= bus.MuxBuf0;
    end
  end

  // Sticky flag for a start request that could not be honoured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= 1'b0;
    end else if (bus.pix_start && (busy || full)) begin
      drop_q <= 1'b1;
    end
  end

  // FIFO occupancy next-state; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and count; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Pixel storage; contents need no reset since the count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {r_q, g_q, b_q};
    end
  end

  assign bus.SelR0      = sel_r_q;
  assign bus.SelG0      = sel_g_q;
  assign bus.SelB0      = sel_b_q;
  assign bus.busy       = busy;
  assign bus.pix_valid  = valid;
  assign bus.pix_out    = valid ? mem[rd_ptr_q] : 24'h0;
  assign bus.fifo_count = count_q;
  assign bus.start_drop = drop_q;

endmodule

// File: tb/tb_buf0_rgb_sequencer.sv
// Self-checking bench for buf0_rgb_sequencer against a queue-based pixel model.
module tb_buf0_rgb_sequencer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  buf0_rgb_sequencer_if #(.AW(AW)) bus ();

  buf0_rgb_sequencer #(.DEPTH(DEPTH), .AW(AW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: phase 0 idle, 1 red, 2 green, 3 blue, 4 push; queue holds stored pixels.
  logic [23:0] mq[$];
  int          phase = 0;
  bit          mdrop = 1'b0;
  logic [23:0] cur   = 24'h0;

  int vecs        = 0;
  int miscompares = 0;

  // Behavioural multiplexer: returns the byte of the current pixel for the active select.
  always_comb begin
    if (bus.SelR0)      bus.MuxBuf0 = cur[23:16];
    else if (bus.SelG0) bus.MuxBuf0 = cur[15:8];
    else if (bus.SelB0) bus.MuxBuf0 = cur[7:0];
    else                bus.MuxBuf0 = 8'h5A;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [23:0] head;
    head = (mq.size() != 0) ? mq[0] : 24'h0;
    chk("sel_r", 32'(bus.SelR0), 32'(phase == 1));
    chk("sel_g", 32'(bus.SelG0), 32'(phase == 2));
    chk("sel_b", 32'(bus.SelB0), 32'(phase == 3));
    chk("busy", 32'(bus.busy), 32'(phase != 0));
    chk("pix_valid", 32'(bus.pix_valid), 32'(mq.size() != 0));
    chk("pix_out", 32'(bus.pix_out), 32'(head));
    chk("fifo_count", 32'(bus.fifo_count), 32'(mq.size()));
    chk("start_drop", 32'(bus.start_drop), 32'(mdrop));
  endtask

  // One clock cycle: drive inputs, check against the model, advance the model, cross the edge.
  task automatic step(input bit start, input bit ready, input logic [23:0] pix);
    bit acc;
    @(negedge clk);
    bus.pix_start = start;
    bus.pix_ready = ready;
    if (phase == 0) cur = pix;
    #1;
    check_outputs();
    acc = (phase == 0) && start && (mq.size() < DEPTH);
    if (start && (phase != 0 || mq.size() == DEPTH)) mdrop = 1'b1;
    if (mq.size() != 0 && ready) void'(mq.pop_front());
    if (phase == 4) mq.push_back(cur);
    if (phase == 0)      phase = acc ? 1 : 0;
    else if (phase == 4) phase = 0;
    else                 phase = phase + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.pix_start = 1'b0;
    bus.pix_ready = 1'b0;
    #1;
    mq.delete();
    phase = 0;
    mdrop = 1'b0;
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [23:0] p;
    int guard;
    bus.pix_start = 1'b0;
    bus.pix_ready = 1'b0;

    // Reset state and a single pixel with known bytes.
    do_reset();
    step(1'b1, 1'b0, 24'hA1B2C3);
    chk("t1_red_cycle", 32'(bus.SelR0), 32'd1);
    step(1'b0, 1'b0, 24'h0);
    chk("t1_grn_cycle", 32'(bus.SelG0), 32'd1);
    step(1'b0, 1'b0, 24'h0);
    chk("t1_blu_cycle", 32'(bus.SelB0), 32'd1);
    step(1'b0, 1'b0, 24'h0);
    chk("t1_push_not_valid", 32'(bus.pix_valid), 32'd0);
    step(1'b0, 1'b0, 24'h0);
    chk("t1_valid", 32'(bus.pix_valid), 32'd1);
    chk("t1_pix", 32'(bus.pix_out), 32'hA1B2C3);
    step(1'b0, 1'b1, 24'h0);

    // Fill the FIFO with starts issued only while idle, then refuse one more.
    for (int i = 0; i < 40; i++) step(phase == 0, 1'b0, 24'($urandom));
    chk("t2_full_count", 32'(bus.fifo_count), 32'd8);
    chk("t2_no_drop_yet", 32'(bus.start_drop), 32'd0);
    step(1'b1, 1'b0, 24'($urandom));
    chk("t2_drop", 32'(bus.start_drop), 32'd1);
    chk("t2_still_idle", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 24'h0);
    chk("t2_empty_count", 32'(bus.fifo_count), 32'd0);
    chk("t2_empty_pix", 32'(bus.pix_out), 32'h0);

    // Seven stored, then a push coinciding with a pop across the pointer wrap.
    guard = 0;
    while ((mq.size() < 7 || phase != 0) && guard < 60) begin
      step((phase == 0) && (mq.size() < 7), 1'b0, 24'($urandom));
      guard++;
    end
    chk("t3_seven", 32'(bus.fifo_count), 32'd7);
    step(1'b1, 1'b0, 24'($urandom));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 24'h0);
    step(1'b0, 1'b1, 24'h0);
    chk("t3_count_held", 32'(bus.fifo_count), 32'd7);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 24'h0);
    chk("t3_drained", 32'(bus.fifo_count), 32'd0);

    // Start pulsed during green is dropped; the pixel in flight is unaffected.
    do_reset();
    p = 24'($urandom);
    step(1'b1, 1'b1, p);
    step(1'b0, 1'b1, 24'h0);
    step(1'b1, 1'b1, 24'h0);
    chk("t4_drop", 32'(bus.start_drop), 32'd1);
    step(1'b0, 1'b1, 24'h0);
    step(1'b0, 1'b1, 24'h0);
    chk("t4_pix", 32'(bus.pix_out), 32'(p));
    step(1'b0, 1'b1, 24'h0);

    // Reset asserted during blue: selects clear at once and nothing is written.
    do_reset();
    step(1'b1, 1'b0, 24'($urandom));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 24'h0);
    step(1'b1, 1'b0, 24'($urandom));
    step(1'b0, 1'b0, 24'h0);
    step(1'b0, 1'b0, 24'h0);
    chk("t5_in_blue", 32'(bus.SelB0), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_sels_async", 32'({bus.SelR0, bus.SelG0, bus.SelB0}), 32'd0);
    chk("t5_count", 32'(bus.fifo_count), 32'd0);
    mq.delete();
    phase = 0;
    mdrop = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    p = 24'($urandom);
    step(1'b1, 1'b0, p);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 24'h0);
    chk("t5_after_pix", 32'(bus.pix_out), 32'(p));
    chk("t5_after_count", 32'(bus.fifo_count), 32'd1);

    // Random start/ready traffic; the model checks selects, data and count every cycle.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, 24'($urandom));
      chk("t6_onehot", 32'($countones({bus.SelR0, bus.SelG0, bus.SelB0}) <= 1), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
